// File: rtl/program_loader_pkg.sv
// Shared processor constants: instruction-memory geometry, end-of-program marker
// and the loader state encoding.
package program_loader_pkg;

    localparam int unsigned ImemAddrW = 8;
    localparam int unsigned ImemDepth = 2 ** ImemAddrW;
    localparam logic [31:0] HaltWord  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StWrite,
        StDone,
        StError
    } loader_state_e;

    // Big-endian assembly: earlier bytes end up in the more significant positions.
    function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                  input logic [7:0]  data);
        return {word[23:0], data};
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four received bytes into one big-endian 32-bit word.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic        valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [31:0] shift_q;
    logic [1:0]  cnt_q;
    logic        accept;

    assign accept = enable_i & valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            shift_q <= 32'd0;
            cnt_q   <= 2'd0;
        end else if (accept) begin
            shift_q <= shift_in_byte(shift_q, byte_i);
            cnt_q   <= cnt_q + 2'd1;
        end
    end

    assign word_o = shift_q;
    // Flags the cycle in which the fourth byte is taken; word_o holds the full word next cycle.
    assign word_ready_o = accept && (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Loads a byte stream into instruction memory, one 32-bit word per four bytes,
// holding the processor in reset until the end-of-program marker has been written.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = ImemAddrW,
    parameter logic [31:0] HALT_WORD = HaltWord
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_imem_wr_en,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_data,
    output logic              o_cpu_rst,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow,
    output logic [ADDR_W:0]   o_word_count
);

    loader_state_e     state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic              wr_en_q;
    logic              busy_q;
    logic              done_q;
    logic              overflow_q;
    logic              cpu_rst_q;

    logic [31:0] asm_word;
    logic        asm_ready;
    logic        asm_enable;
    logic        asm_clear;
    logic        session_idle;
    logic        word_is_halt;
    logic        addr_at_end;

    assign session_idle = (state_q == StIdle) || (state_q == StDone) || (state_q == StError);
    assign word_is_halt = (asm_word == HALT_WORD);
    assign addr_at_end  = (addr_q == '1);

    // A byte arriving during WRITE already belongs to the next word, unless the session ends here.
    assign asm_enable = (state_q == StRecv) ||
                        ((state_q == StWrite) && !word_is_halt && !addr_at_end);
    assign asm_clear  = session_idle && i_start;

    word_assembler u_word_assembler (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (asm_clear),
        .enable_i     (asm_enable),
        .valid_i      (i_rx_valid),
        .byte_i       (i_rx_data),
        .word_o       (asm_word),
        .word_ready_o (asm_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            count_q    <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            cpu_rst_q  <= 1'b1;
        end else begin
            wr_en_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone, StError: begin
                    if (i_start) begin
                        state_q    <= StRecv;
                        addr_q     <= '0;
                        count_q    <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        overflow_q <= 1'b0;
                        cpu_rst_q  <= 1'b1;
                    end
                end
                StRecv: begin
                    if (asm_ready) begin
                        state_q <= StWrite;
                        wr_en_q <= 1'b1;
                    end
                end
                StWrite: begin
                    count_q <= count_q + (ADDR_W + 1)'(1);
                    if (word_is_halt) begin
                        state_q   <= StDone;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        cpu_rst_q <= 1'b0;
                    end else if (addr_at_end) begin
                        // Memory full: stop rather than wrap over the start of the program.
                        state_q    <= StError;
                        busy_q     <= 1'b0;
                        overflow_q <= 1'b1;
                    end else begin
                        state_q <= StRecv;
                        addr_q  <= addr_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_wr_en = wr_en_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_data  = asm_word;
    assign o_cpu_rst    = cpu_rst_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_overflow   = overflow_q;
    assign o_word_count = count_q;

endmodule
